// File: rtl/out_word_tx.sv
// out_word_tx: FIFO-buffered 16-bit word transmitter, two UART byte frames per word.
// Define OUT_WORD_TX_PARITY_EN to add an even-parity bit to every byte frame.
module out_word_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic        full,
    output logic        empty,
    output logic        busy,
    output logic        overflow,
    output logic        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_CNT   = CW'(FIFO_DEPTH);

`ifdef OUT_WORD_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          push, pop;

    state_t        state_q;
    logic [15:0]   shift_q;
    logic [2:0]    bit_q;
    logic          byte_q;
    logic [BW-1:0] baud_q;
    logic          par_q;
    logic          tx_q;

    assign full     = (cnt_q == DEPTH_CNT);
    assign empty    = (cnt_q == '0);
    assign busy     = (state_q != IDLE);
    assign overflow = ovf_q;
    assign tx       = tx_q;

    // A write offered while full is dropped even if a pop frees a slot this edge.
    assign push = wr_en && !full;
    assign pop  = (state_q == IDLE) && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q | (wr_en & full);
        if (push)
            wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push)
            mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            byte_q  <= 1'b0;
            baud_q  <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        byte_q  <= 1'b0;
                        baud_q  <= BAUD_RELOAD;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_q != '0) begin
                        baud_q <= baud_q - BW'(1);
                    end else begin
                        baud_q  <= BAUD_RELOAD;
                        tx_q    <= shift_q[0];
                        par_q   <= shift_q[0];
                        shift_q <= {1'b0, shift_q[15:1]};
                        bit_q   <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (baud_q != '0) begin
                        baud_q <= baud_q - BW'(1);
                    end else begin
                        baud_q <= BAUD_RELOAD;
                        if (bit_q != 3'd7) begin
                            tx_q    <= shift_q[0];
                            par_q   <= par_q ^ shift_q[0];
                            shift_q <= {1'b0, shift_q[15:1]};
                            bit_q   <= bit_q + 3'd1;
                        end else begin
`ifdef OUT_WORD_TX_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end
                    end
                end
`ifdef OUT_WORD_TX_PARITY_EN
                PARITY: begin
                    if (baud_q != '0) begin
                        baud_q <= baud_q - BW'(1);
                    end else begin
                        baud_q  <= BAUD_RELOAD;
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_q != '0) begin
                        baud_q <= baud_q - BW'(1);
                    end else if (!byte_q) begin
                        // Low byte done: shift_q[7:0] now holds the high byte.
                        baud_q  <= BAUD_RELOAD;
                        byte_q  <= 1'b1;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end else begin
                        byte_q  <= 1'b0;
                        tx_q    <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
